// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch datapath: four BCD digits advanced once per prescaled tick,
// up (wrapping at 59:59) or down (holding at 00:00), with stopped-state presets.
module stopwatch_counter #(
  parameter int TICK_DIV = 100000000,
  parameter int CNT_W    = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       running,
  input  logic       dir,
  input  logic       clear_pulse,
  input  logic       inc_min,
  input  logic       inc_sec,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       at_zero,
  output logic       tick
);

  localparam logic [CNT_W-1:0] TC = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] presc;
  logic [7:0]       sec_q;
  logic [7:0]       min_q;
  logic             tick_q;
  logic             tick_int;

  // Two-digit BCD field in the range 00-59, wrapping in both directions.
  function automatic logic [7:0] bcd60_inc(input logic [7:0] f);
    if (f[3:0] != 4'd9)      return {f[7:4], f[3:0] + 4'd1};
    else if (f[7:4] != 4'd5) return {f[7:4] + 4'd1, 4'd0};
    else                     return 8'h00;
  endfunction

  function automatic logic [7:0] bcd60_dec(input logic [7:0] f);
    if (f[3:0] != 4'd0)      return {f[7:4], f[3:0] - 4'd1};
    else if (f[7:4] != 4'd0) return {f[7:4] - 4'd1, 4'd9};
    else                     return 8'h59;
  endfunction

  assign tick_int = running && !clear_pulse && (presc == TC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc  <= '0;
      sec_q  <= 8'h00;
      min_q  <= 8'h00;
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_int;
      if (clear_pulse) begin
        presc <= '0;
        sec_q <= 8'h00;
        min_q <= 8'h00;
      end else if (running) begin
        if (tick_int) begin
          presc <= '0;
          if (dir) begin
            sec_q <= bcd60_inc(sec_q);
            if (sec_q == 8'h59) min_q <= bcd60_inc(min_q);
          end else if ({min_q, sec_q} != 16'h0000) begin
            // Nonzero time with zero seconds implies nonzero minutes to borrow from.
            sec_q <= bcd60_dec(sec_q);
            if (sec_q == 8'h00) min_q <= bcd60_dec(min_q);
          end
        end else begin
          presc <= presc + CNT_W'(1);
        end
      end else begin
        if (inc_sec) sec_q <= bcd60_inc(sec_q);
        if (inc_min) min_q <= bcd60_inc(min_q);
      end
    end
  end

  assign min_tens = min_q[7:4];
  assign min_ones = min_q[3:0];
  assign sec_tens = sec_q[7:4];
  assign sec_ones = sec_q[3:0];
  assign tick     = tick_q;
  assign at_zero  = ({min_q, sec_q} == 16'h0000) && !dir;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: directed scenarios then random stimulus, all
// checked each cycle against a seconds-based reference model.
module tb_stopwatch_counter;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic running = 1'b0, dir = 1'b0, clear_pulse = 1'b0, inc_min = 1'b0, inc_sec = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic at_zero, tick;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: total seconds 0..3599 and prescaler phase.
  int t  = 0;
  int ph = 0;
  bit mtick = 1'b0;

  stopwatch_counter #(.TICK_DIV(TD), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .running(running), .dir(dir),
    .clear_pulse(clear_pulse), .inc_min(inc_min), .inc_sec(inc_sec),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens),
    .sec_ones(sec_ones), .at_zero(at_zero), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] digits();
    return {16'h0, min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  function automatic logic [31:0] exp_digits();
    int m, s;
    m = t / 60;
    s = t % 60;
    return 32'((m / 10) * 4096 + (m % 10) * 256 + (s / 10) * 16 + (s % 10));
  endfunction

  task automatic model_edge();
    int m, s;
    mtick = 1'b0;
    if (clear_pulse) begin
      t = 0; ph = 0;
    end else if (running) begin
      if (ph == TD - 1) begin
        ph = 0;
        mtick = 1'b1;
        if (dir) t = (t + 1) % 3600;
        else if (t > 0) t = t - 1;
      end else begin
        ph = ph + 1;
      end
    end else begin
      m = t / 60;
      s = t % 60;
      if (inc_sec) s = (s + 1) % 60;
      if (inc_min) m = (m + 1) % 60;
      t = m * 60 + s;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_digits"}, digits(), exp_digits());
    chk({tag, "_tick"}, 32'(tick), 32'(mtick));
    chk({tag, "_at_zero"}, 32'(at_zero), 32'((t == 0) && !dir));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all("cyc");
  endtask

  task automatic pulse_preset(input bit is_min);
    if (is_min) inc_min = 1'b1; else inc_sec = 1'b1;
    cycle();
    inc_min = 1'b0;
    inc_sec = 1'b0;
    cycle();
  endtask

  task automatic wait_tick(input int max_cyc);
    int k = 0;
    do begin
      cycle();
      k++;
    end while (!tick && k < max_cyc);
    chk("tick_seen", 32'(tick), 32'd1);
  endtask

  task automatic do_clear();
    running = 1'b0;
    clear_pulse = 1'b1;
    cycle();
    clear_pulse = 1'b0;
  endtask

  initial begin
    int nt;
    #12;
    check_all("reset");
    chk("reset_at_zero", 32'(at_zero), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Up count from zero: three ticks in twelve cycles.
    running = 1'b1; dir = 1'b1;
    nt = 0;
    repeat (12) begin
      cycle();
      if (tick) nt++;
    end
    chk("up12_time", digits(), 32'h0003);
    chk("up12_ticks", 32'(nt), 32'd3);

    // Preset 59:58 and wrap through 00:00.
    do_clear();
    for (int i = 0; i < 59; i++) pulse_preset(1'b1);
    for (int i = 0; i < 58; i++) pulse_preset(1'b0);
    chk("preset_5958", digits(), 32'h5958);
    running = 1'b1; dir = 1'b1;
    wait_tick(2 * TD);
    chk("up_5959", digits(), 32'h5959);
    wait_tick(2 * TD);
    chk("wrap_0000", digits(), 32'h0000);
    chk("wrap_at_zero", 32'(at_zero), 32'd0);

    // Down count: borrow across minutes, then hold at zero.
    do_clear();
    pulse_preset(1'b1);
    dir = 1'b0; running = 1'b1;
    wait_tick(2 * TD);
    chk("borrow_0059", digits(), 32'h0059);
    do_clear();
    pulse_preset(1'b0);
    dir = 1'b0; running = 1'b1;
    wait_tick(2 * TD);
    chk("down_0000", digits(), 32'h0000);
    chk("down_at_zero", 32'(at_zero), 32'd1);
    wait_tick(2 * TD);
    chk("hold_0000", digits(), 32'h0000);

    // Pause mid-period: prescaler holds its phase.
    do_clear();
    dir = 1'b1; running = 1'b1;
    cycle(); cycle();
    running = 1'b0;
    repeat (10) cycle();
    running = 1'b1;
    cycle();
    chk("resume_no_tick", 32'(tick), 32'd0);
    cycle();
    chk("resume_tick", 32'(tick), 32'd1);

    // Presets ignored while running; clear beats preset.
    inc_sec = 1'b1;
    cycle();
    inc_sec = 1'b0;
    chk("inc_while_run", digits(), 32'h0001);
    running = 1'b0;
    clear_pulse = 1'b1; inc_sec = 1'b1;
    cycle();
    clear_pulse = 1'b0; inc_sec = 1'b0;
    chk("clear_over_inc", digits(), 32'h0000);
    running = 1'b1;
    repeat (3) cycle();
    chk("clear_presc_a", 32'(tick), 32'd0);
    cycle();
    chk("clear_presc_b", 32'(tick), 32'd1);

    // Asynchronous reset between edges.
    repeat (6) cycle();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    t = 0; ph = 0; mtick = 1'b0;
    #1;
    chk("async_rst_digits", digits(), 32'h0000);
    chk("async_rst_tick", 32'(tick), 32'd0);
    cycle();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (TD + 1) cycle();
    chk("after_rst", digits(), 32'h0001);

    // Random phase.
    repeat (600) begin
      running     = ($urandom_range(0, 3) != 0);
      dir         = 1'($urandom_range(0, 1));
      clear_pulse = ($urandom_range(0, 63) == 0);
      inc_min     = ($urandom_range(0, 2) == 0);
      inc_sec     = ($urandom_range(0, 2) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
Timekeeping datapath driven by the stopwatch controller's running/dir/clear_pulse outputs. Holds an MM:SS time value in four BCD digits and advances it once per prescaled tick, up or down. Feeds the at_zero status back to the controller. Also accepts minute/second preset increments while stopped, for setting countdown times.

Parameters:
TICK_DIV, 100000000, clk cycles per count tick (1 Hz at 100 MHz); legal minimum 2
CNT_W, 27, prescaler width; must satisfy 2**CNT_W >= TICK_DIV

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
running  input  1  count enable from controller
dir  input  1  1 = count up, 0 = count down
clear_pulse  input  1  zero time value and prescaler
inc_min  input  1  single-cycle pulse: add one to minutes; ignored while running
inc_sec  input  1  single-cycle pulse: add one to seconds; ignored while running
min_tens  output  4  BCD, range 0-5
min_ones  output  4  BCD, range 0-9
sec_tens  output  4  BCD, range 0-5
sec_ones  output  4  BCD, range 0-9
at_zero  output  1  time == 00:00 and dir == 0
tick  output  1  one-cycle pulse on each count advance

Behaviour:
- Reset (rst_n low, async): all digits 0, prescaler 0, tick 0. at_zero then follows its decode, giving 1 if dir == 0.
- Prescaler:
  - Increments while running == 1.
  - Holds its value while running == 0, so stop/start resumes mid-second.
  - On reaching TICK_DIV-1 it returns to 0 and raises the internal tick for one cycle.
- tick output: registered copy of the internal tick, high in the same cycle the digits show the new value.
- Up count (dir = 1), on each tick:
  - sec_ones 9->0 carries into sec_tens.
  - sec_tens 5->0 carries into min_ones.
  - min_ones 9->0 carries into min_tens.
  - 59:59 -> 00:00 wraps and counting continues.
- Down count (dir = 0), on each tick:
  - Borrows mirror the up-count carries.
  - 00:00 holds at 00:00 and never wraps. The tick output still pulses.
- at_zero:
  - Combinational decode of the registered digits: all four digits == 0 AND dir == 0.
  - Never asserts in up mode, so up-counting from 00:00 is not stopped by the controller.
  - Rises in the same cycle the digits become 00:00.
- Presets (only when running == 0):
  - inc_sec: seconds field +1; 59 -> 00 with no carry into minutes.
  - inc_min: minutes field +1; 59 -> 00.
  - Both in the same cycle: both applied.
- Priority, per cycle: clear_pulse > tick advance > inc_min/inc_sec.
  - clear_pulse zeroes the digits and the prescaler regardless of running.
- Width rules:
  - Digits never leave their BCD range.
  - The prescaler compare uses TICK_DIV-1, sized to CNT_W.
- rst_n asserted mid-count: immediate asynchronous zeroing. Counting resumes only after release and on running.

Test Plan:
- TICK_DIV=4, reset, running=1, dir=1 for 12 clk -> time 00:03, tick pulsed 3 times at 4-cycle spacing, at_zero=0 throughout.
- Preset 59:58 via 59 inc_min and 58 inc_sec pulses while stopped, then run up 2 ticks -> 59:59 then 00:00, at_zero stays 0.
- Preset 01:00, dir=0, run 1 tick -> 00:59 (borrow across minutes). Preset 00:01, run 1 tick -> 00:00 with at_zero=1 in the same cycle; a further tick keeps 00:00.
- Run 2 cycles into a tick period, drop running for 10 cycles, reassert -> next advance occurs 2 cycles after reassert (prescaler held).
- Assert inc_sec while running=1 -> no change. Assert clear_pulse and inc_sec in the same stopped cycle -> 00:00 and prescaler 0.
- Pull rst_n low asynchronously between clk edges mid-count -> digits read 0 before the next clk edge.
